// File: rtl/pc_unit_gen_pkg.sv
// Shared types and defaults for the program-counter unit: FSM states,
// next-PC source codes (also used as the trace encoding) and vectors.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SRC_SEQ    = 3'd0,
    SRC_BRANCH = 3'd1,
    SRC_JUMP   = 3'd2,
    SRC_JR     = 3'd3,
    SRC_EXC    = 3'd4,
    SRC_ERET   = 3'd5,
    SRC_RESET  = 3'd6,
    SRC_HOLD   = 3'd7
  } src_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;

endpackage

// File: rtl/pc_unit_gen_if.sv
// Control/result bundle between the control unit and the PC unit.
// Trace signals exist only when PC_UNIT_GEN_TRACE_EN is defined.
interface pc_unit_gen_if #(
  parameter int PC_W  = 32,
  parameter int IMM_W = 16
);
  logic             Stall;
  logic             Branch;
  logic [IMM_W-1:0] Offset;
  logic             Jump;
  logic [25:0]      JumpAddr;
  logic             JumpReg;
  logic [PC_W-1:0]  RegTarget;
  logic             Exc;
  logic             Eret;
  logic             Halt;
  logic             Resume;
  logic [PC_W-1:0]  PC;
  logic [PC_W-1:0]  PcPlus4;
  logic [PC_W-1:0]  Epc;
  logic             PcValid;
  logic             Misalign;
`ifdef PC_UNIT_GEN_TRACE_EN
  logic             TraceValid;
  logic [2:0]       TraceSrc;
`endif

  modport master (
    output Stall, Branch, Offset, Jump, JumpAddr, JumpReg, RegTarget,
    output Exc, Eret, Halt, Resume,
`ifdef PC_UNIT_GEN_TRACE_EN
    input  TraceValid, TraceSrc,
`endif
    input  PC, PcPlus4, Epc, PcValid, Misalign
  );

  modport slave (
    input  Stall, Branch, Offset, Jump, JumpAddr, JumpReg, RegTarget,
    input  Exc, Eret, Halt, Resume,
`ifdef PC_UNIT_GEN_TRACE_EN
    output TraceValid, TraceSrc,
`endif
    output PC, PcPlus4, Epc, PcValid, Misalign
  );
endinterface

// File: rtl/pc_unit_gen_next_sel.sv
// Combinational next-PC priority mux with PC+4, branch and jump target adders.
// When not running, the current PC is held and reported as SRC_HOLD.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int IMM_W = 16
) (
  input  logic             run,
  input  logic             stall,
  input  logic             branch,
  input  logic             jump,
  input  logic             jump_reg,
  input  logic             exc,
  input  logic             eret,
  input  logic [IMM_W-1:0] offset,
  input  logic [25:0]      jump_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  reg_target,
  input  logic [PC_W-1:0]  epc,
  input  logic [PC_W-1:0]  exc_vec,
  output logic [PC_W-1:0]  pc_plus4,
  output logic [PC_W-1:0]  pc_next,
  output logic             misalign,
  output src_e             src
);

  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] jmp_tgt;

  assign pc_plus4 = pc + PC_W'(4);
  assign off_ext  = PC_W'($signed(offset));
  assign br_tgt   = pc_plus4 + (off_ext << 2);

  // Upper PC bits above 27 come from PC+4; with PC_W=28 nothing is kept.
  always_comb begin
    jmp_tgt        = pc_plus4;
    jmp_tgt[27:0]  = {jump_addr, 2'b00};
  end

  always_comb begin
    pc_next = pc;
    src     = SRC_HOLD;
    if (run) begin
      if (exc) begin
        pc_next = exc_vec;
        src     = SRC_EXC;
      end else if (eret) begin
        pc_next = epc;
        src     = SRC_ERET;
      end else if (stall) begin
        pc_next = pc;
        src     = SRC_HOLD;
      end else if (jump_reg) begin
        pc_next = reg_target;
        src     = SRC_JR;
      end else if (jump) begin
        pc_next = jmp_tgt;
        src     = SRC_JUMP;
      end else if (branch) begin
        pc_next = br_tgt;
        src     = SRC_BRANCH;
      end else begin
        pc_next = pc_plus4;
        src     = SRC_SEQ;
      end
    end
  end

  assign misalign = |pc_next[1:0];

endmodule

// File: rtl/pc_unit_gen.sv
// Program-counter unit: run/halt FSM, PC and EPC registers, fetch-valid flag.
// Optional trace outputs enabled by defining PC_UNIT_GEN_TRACE_EN.
//
// state  | meaning
// BOOT   | first cycle after reset, PC = reset vector, no fetch
// RUN    | PC advances every cycle, fetch valid
// HALTED | PC frozen, no fetch, waits for Resume
module pc_unit_gen
  import pc_pkg::*;
#(
  parameter int          PC_W      = 32,
  parameter int          IMM_W     = 16,
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC
) (
  input logic         Clk,
  input logic         PcReSet,
  pc_unit_gen_if.slave bus
);

  localparam logic [PC_W-1:0] RESET_PC = RESET_VEC[PC_W-1:0];
  localparam logic [PC_W-1:0] EXC_PC   = EXC_VEC[PC_W-1:0];

  state_e          state;
  state_e          state_nx;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] epc;
  logic            pc_valid;
  src_e            src;

  pc_next_sel #(.PC_W(PC_W), .IMM_W(IMM_W)) u_next_sel (
    .run        (state == RUN),
    .stall      (bus.Stall),
    .branch     (bus.Branch),
    .jump       (bus.Jump),
    .jump_reg   (bus.JumpReg),
    .exc        (bus.Exc),
    .eret       (bus.Eret),
    .offset     (bus.Offset),
    .jump_addr  (bus.JumpAddr),
    .pc         (pc),
    .reg_target (bus.RegTarget),
    .epc        (epc),
    .exc_vec    (EXC_PC),
    .pc_plus4   (bus.PcPlus4),
    .pc_next    (pc_next),
    .misalign   (bus.Misalign),
    .src        (src)
  );

  always_ff @(posedge Clk) begin
    if (PcReSet) state <= BOOT;
    else         state <= state_nx;
  end

  // Halt is evaluated alongside this cycle's PC update, so a redirect
  // (including an exception) still lands before the unit freezes.
  always_comb begin
    state_nx = state;
    unique case (state)
      BOOT:    state_nx = RUN;
      RUN:     if (bus.Halt && !bus.Stall) state_nx = HALTED;
      HALTED:  if (bus.Resume) state_nx = RUN;
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (PcReSet) begin
      pc       <= RESET_PC;
      epc      <= '0;
      pc_valid <= 1'b0;
    end else begin
      pc       <= pc_next;
      pc_valid <= (state_nx == RUN);
      if (src == SRC_EXC) epc <= pc;
    end
  end

  assign bus.PC      = pc;
  assign bus.Epc     = epc;
  assign bus.PcValid = pc_valid;

`ifdef PC_UNIT_GEN_TRACE_EN
  logic [2:0] trace_src;

  always_ff @(posedge Clk) begin
    if (PcReSet) trace_src <= SRC_RESET;
    else         trace_src <= src;
  end

  assign bus.TraceValid = pc_valid;
  assign bus.TraceSrc   = trace_src;
`endif

endmodule

// File: tb/tb_pc_unit_gen.sv
// Directed bench for pc_unit_gen: stimulus pushes expected values tagged with
// the cycle they must appear in; a monitor pops and compares at each negedge.
module tb_pc_unit_gen;
  import pc_pkg::*;

  localparam int K_PC    = 0;
  localparam int K_VALID = 1;
  localparam int K_EPC   = 2;
  localparam int K_PLUS4 = 3;
  localparam int K_MIS   = 4;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic Clk;
  logic PcReSet;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;

  pc_unit_gen_if #(.PC_W(32), .IMM_W(16)) bus ();

  pc_unit_gen #(.PC_W(32), .IMM_W(16)) dut (
    .Clk     (Clk),
    .PcReSet (PcReSet),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int k);
    case (k)
      K_PC:    return bus.PC;
      K_VALID: return {31'd0, bus.PcValid};
      K_EPC:   return bus.Epc;
      K_PLUS4: return bus.PcPlus4;
      default: return {31'd0, bus.Misalign};
    endcase
  endfunction

  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || actual(e.kind) !== e.val) begin
        errors++;
        $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, actual(e.kind), e.val);
      end
    end
  end

  task automatic push(int dc, int k, logic [31:0] v, string nm);
    exp_t x;
    x.cyc  = cyc + dc;
    x.kind = k;
    x.val  = v;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    bus.Stall     = 1'b0;
    bus.Branch    = 1'b0;
    bus.Offset    = '0;
    bus.Jump      = 1'b0;
    bus.JumpAddr  = '0;
    bus.JumpReg   = 1'b0;
    bus.RegTarget = '0;
    bus.Exc       = 1'b0;
    bus.Eret      = 1'b0;
    bus.Halt      = 1'b0;
    bus.Resume    = 1'b0;
  endtask

  task automatic jr(logic [31:0] t, string nm);
    clr();
    bus.JumpReg   = 1'b1;
    bus.RegTarget = t;
    push(1, K_PC, t, nm);
    tick();
  endtask

  initial begin
    PcReSet = 1'b1;
    clr();
    tick();
    tick();
    PcReSet = 1'b0;
    push(0, K_PC,    32'h0000_3000, "rst_pc");
    push(0, K_VALID, 32'd0,         "rst_valid");
    push(0, K_EPC,   32'd0,         "rst_epc");
    push(1, K_PC,    32'h0000_3000, "boot_pc");
    push(1, K_VALID, 32'd1,         "boot_valid");
    tick();
    push(0, K_MIS, 32'd0, "seq_misalign");
    push(1, K_PC, 32'h0000_3004, "seq1");
    tick();
    push(1, K_PC, 32'h0000_3008, "seq2");
    tick();

    bus.Branch = 1'b1; bus.Offset = 16'hFFFE;
    push(0, K_PLUS4, 32'h0000_300C, "plus4");
    push(1, K_PC, 32'h0000_3004, "branch_back");
    tick();
    bus.Offset = 16'h0003;
    push(1, K_PC, 32'h0000_3014, "branch_fwd");
    tick();
    bus.Offset = 16'hFFFE;
    push(1, K_PC, 32'h0000_3010, "branch_back2");
    tick();

    clr();
    bus.Jump = 1'b1; bus.JumpAddr = 26'h0000C10; bus.Branch = 1'b1; bus.Offset = 16'h0010;
    push(1, K_PC, 32'h0000_3040, "jump_over_branch");
    tick();
    bus.JumpReg = 1'b1; bus.RegTarget = 32'h0000_5000;
    push(1, K_PC, 32'h0000_5000, "jr_over_jump");
    tick();

    jr(32'h0000_3020, "jr_3020");
    clr();
    bus.Exc = 1'b1; bus.Stall = 1'b1;
    push(1, K_PC,  32'h0000_4180, "exc_pc");
    push(1, K_EPC, 32'h0000_3020, "exc_epc");
    tick();
    clr();
    push(1, K_PC, 32'h0000_4184, "exc_seq");
    tick();
    bus.Eret = 1'b1;
    push(1, K_PC, 32'h0000_3020, "eret_pc");
    tick();
    clr();
    bus.Stall = 1'b1;
    push(1, K_PC, 32'h0000_3020, "stall_hold");
    tick();

    jr(32'h0000_3030, "jr_3030");
    clr();
    bus.Halt = 1'b1;
    push(1, K_PC,    32'h0000_3034, "halt_pc");
    push(1, K_VALID, 32'd0,         "halt_valid");
    tick();
    clr();
    bus.Jump = 1'b1; bus.JumpAddr = 26'h0000100; bus.Halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(0, K_PC,    32'h0000_3034, "halted_pc");
      push(0, K_VALID, 32'd0,         "halted_valid");
      tick();
    end
    clr();
    bus.Resume = 1'b1;
    push(1, K_VALID, 32'd1,         "resume_valid");
    push(1, K_PC,    32'h0000_3034, "resume_pc");
    tick();
    clr();
    push(1, K_PC, 32'h0000_3038, "after_resume");
    tick();

    bus.Halt = 1'b1;
    push(1, K_PC, 32'h0000_303C, "halt2_pc");
    tick();
    clr();
    PcReSet = 1'b1;
    push(1, K_PC,    32'h0000_3000, "halted_rst_pc");
    push(1, K_VALID, 32'd0,         "halted_rst_valid");
    tick();
    PcReSet = 1'b0;
    push(1, K_PC,    32'h0000_3000, "reboot_pc");
    push(1, K_VALID, 32'd1,         "reboot_valid");
    tick();

    bus.Exc = 1'b1; bus.Halt = 1'b1;
    push(1, K_PC,    32'h0000_4180, "halt_exc_pc");
    push(1, K_EPC,   32'h0000_3000, "halt_exc_epc");
    push(1, K_VALID, 32'd0,         "halt_exc_valid");
    tick();
    clr();
    bus.Resume = 1'b1;
    push(1, K_PC, 32'h0000_4180, "resume2_pc");
    tick();
    clr();
    bus.Eret = 1'b1;
    push(1, K_PC, 32'h0000_3000, "eret2_pc");
    tick();

    jr(32'hFFFF_FFFC, "jr_top");
    clr();
    push(0, K_PLUS4, 32'h0000_0000, "wrap_plus4");
    push(1, K_PC,    32'h0000_0000, "wrap_pc");
    tick();
    bus.JumpReg = 1'b1; bus.RegTarget = 32'h0000_3002;
    push(0, K_MIS, 32'd1,         "misalign_flag");
    push(1, K_PC,  32'h0000_3002, "misalign_pc");
    tick();
    clr();
    tick();
    tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_unit_gen.md
Name: pc_unit_gen

Overview:
Parametrised program-counter unit for the single-cycle/multicycle MIPS core; the next generation of the current PC block. Holds the fetch PC and selects the next PC from sequential, branch, jump, jump-register, exception and return (eret) sources with fixed priority. Adds stall hold, halt/resume control with a small FSM, a fetch-valid output and an EPC capture register. Sits between the control unit/ALU compare path and instruction memory.

Parameters:
PC_W, 32, PC width in bits; legal 28..32; jump field fills bits [27:0].
IMM_W, 16, branch offset width; sign-extended to PC_W then shifted left 2.
RESET_VEC, 32'h0000_3000, PC value loaded on reset, truncated to PC_W.
EXC_VEC, 32'h0000_4180, exception handler entry, truncated to PC_W.

Ports:
Clk  in  1  rising-edge clock
PcReSet  in  1  synchronous active-high reset
Stall  in  1  hold PC for this cycle
Branch  in  1  taken-branch request
Offset  in  IMM_W  branch word offset, signed
Jump  in  1  J/JAL request
JumpAddr  in  26  J-type instr_index
JumpReg  in  1  JR/JALR request
RegTarget  in  PC_W  register jump target
Exc  in  1  exception request
Eret  in  1  return from exception
Halt  in  1  enter HALTED
Resume  in  1  leave HALTED
PC  out  PC_W  current fetch address (registered)
PcPlus4  out  PC_W  PC+4 (combinational)
Epc  out  PC_W  captured exception PC (registered)
PcValid  out  1  PC is a valid fetch this cycle (registered)
Misalign  out  1  selected next PC has bits[1:0] != 0 (combinational)

Behaviour:
- Reset: only on posedge Clk while PcReSet=1. Reset is synchronous and active-high; the design has one clock, Clk. PC=RESET_VEC, Epc=0, PcValid=0, state=BOOT. Reset overrides every other input, including mid-halt or mid-exception.
- FSM states:
  - BOOT: one cycle after reset, PC holds RESET_VEC and PcValid=0. Moves to RUN unconditionally.
  - RUN: PcValid=1. Goes to HALTED when Halt=1 and Stall=0.
  - HALTED: PC holds and PcValid=0. Goes to RUN on Resume=1. Halt is ignored in HALTED. Resume is ignored outside HALTED.
- The PC update occurs only in RUN. Priority (highest first):
  1. Exc: Epc<=PC, PC<=EXC_VEC. Overrides Stall.
  2. Eret: PC<=Epc.
  3. Stall: PC holds.
  4. JumpReg: PC<=RegTarget.
  5. Jump: PC<={PcPlus4[PC_W-1:28], JumpAddr, 2'b00}. When PC_W=28 the upper field is empty.
  6. Branch: PC<=PcPlus4 + (sext(Offset)<<2).
  7. Else: PC<=PcPlus4.
- Halt together with Exc in RUN: the exception redirect happens and the FSM still enters HALTED.
- The halt request takes effect after the current cycle's PC update.
- There are no delay slots. Branch and jump targets are computed from the current PC's PcPlus4.
- All arithmetic is modulo 2^PC_W. PC+4 and branch targets wrap silently; for example, PC=FFFF_FFFC gives PcPlus4=0.
- Misalign is computed on the selected next PC. It only flags: PC is still loaded and no exception is raised internally.
- Simultaneous Jump, JumpReg and Branch are legal; priority resolves them.

Optional Feature:
Macro PC_UNIT_GEN_TRACE_EN.
- Defined: adds output TraceValid (1 bit) and output TraceSrc (3 bits, registered). TraceSrc encodes the source that produced the current PC: 0 seq, 1 branch, 2 jump, 3 jr, 4 exc, 5 eret, 6 reset, 7 hold. TraceValid mirrors PcValid.
- Undefined: neither port exists, and the logic and timing are identical otherwise.

Decomposition:
- Shared package pc_pkg holds:
  - state encoding: BOOT=2'd0, RUN=2'd1, HALTED=2'd2;
  - TraceSrc encodings;
  - default RESET_VEC and EXC_VEC constants.
- One sub-module, pc_next_sel: purely combinational priority mux and target adders. It produces the next PC, Misalign and the source code. The top module keeps the FSM, the PC and Epc registers.

Test Plan:
- Reset: PcReSet=1 for 2 cycles, then release -> PC=0000_3000, PcValid=0 for one cycle, then PcValid=1 and PC advances 3000->3004->3008.
- Branch: at PC=0000_3008, Branch=1, Offset=16'hFFFE -> PC=0000_3004. At PC=0000_3004, Offset=16'h0003 -> PC=0000_3014.
- Jump priority: at PC=0000_3010, Jump=1, JumpAddr=26'h0000C10, Branch=1 -> PC=0000_3040. JumpReg=1, RegTarget=0000_5000 asserted with Jump -> PC=0000_5000.
- Exception and return: at PC=0000_3020, Exc=1 and Stall=1 together -> PC=0000_4180, Epc=0000_3020. A later Eret=1 -> PC=0000_3020.
- Halt: Halt=1 at PC=0000_3030 -> next PC=0000_3034, HALTED, PcValid=0, and PC stays 0000_3034 for 5 cycles. Resume=1 -> RUN, PcValid=1, then 3038. PcReSet while HALTED -> PC=0000_3000, state BOOT.
- Wrap and misalign: with PC forced to FFFF_FFFC via JumpReg -> next PC=0000_0000. RegTarget=0000_3002 -> Misalign=1 in that cycle and PC=0000_3002.
